dmem_ram_bank: RTL and testbench
================================

DMEM_RAM_BANK -- requirements
Module: dmem_ram_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data word width in bits, a multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 129600: number of words.
REQ-003 SHALL have parameter ADDR_W, default 32: address width in bits.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port req, input, 1 bit: access request for the current cycle.
REQ-008 SHALL have port we, input, 1 bit: write when req=1, read when req=0 is not implied (see REQ-014).
REQ-009 SHALL have port be, input, DATA_W/8 bits: byte enables for writes.
REQ-010 SHALL have port address, input, ADDR_W bits: word address.
REQ-011 SHALL have port wd, input, DATA_W bits: write data.
REQ-012 SHALL have outputs rd (DATA_W bits, read data), rd_valid (1 bit, read data valid), oob_err (1 bit, out-of-range pulse) and busy (1 bit, dump in progress).
REQ-013 SHALL have dump ports dump_start (input, 1), dump_ready (input, 1), dump_valid (output, 1), dump_addr (output, ADDR_W), dump_data (output, DATA_W) and dump_done (output, 1).

Function
REQ-014 SHALL treat req=1, we=0 as a read and req=1, we=1 as a write; req=0 means no access.
REQ-015 SHALL complete a read with fixed 1-cycle latency: rd and rd_valid are registered at the edge after the request, and rd_valid pulses for exactly 1 cycle.
REQ-016 SHALL hold rd at its last value while rd_valid=0.
REQ-017 SHALL write at the rising edge only the bytes whose be bit is 1; all other bytes keep their old value.
REQ-018 SHALL treat address >= DEPTH as out of range: a read returns rd=0 with rd_valid=1, a write is discarded, and oob_err pulses 1 cycle, aligned with rd_valid on a read.
REQ-019 SHALL be read-first on a same-cycle collision: a read from the address being written returns the old data.
REQ-020 SHALL implement the dump FSM with states IDLE, DUMP and DONE.
REQ-021 SHALL move IDLE->DUMP on dump_start=1: set dump_addr=0, busy=1, dump_valid=1.
REQ-022 SHALL, in DUMP, present dump_data = mem[dump_addr] combinationally from the word array.
REQ-023 SHALL, in DUMP, advance dump_addr by 1 on a beat (dump_valid & dump_ready), and hold dump_addr/dump_data stable while dump_ready=0.
REQ-024 SHALL move DUMP->DONE on the beat at dump_addr=DEPTH-1, with no wrap past the last word.
REQ-025 SHALL, in DONE, drive dump_done=1 and dump_valid=0 for 1 cycle, then return to IDLE and drop busy.
REQ-026 SHALL ignore req while busy=1: no write occurs, rd_valid stays 0 and oob_err stays 0; the requester stalls on busy.
REQ-027 SHALL ignore dump_start outside IDLE.

Reset
REQ-028 SHALL drive on reset: FSM=IDLE, rd=0, rd_valid=0, oob_err=0, busy=0, dump_valid=0, dump_addr=0, dump_done=0.
REQ-029 SHALL not clear memory contents on reset.
REQ-030 SHALL let reset abort a dump immediately, returning to IDLE with no dump_done pulse.
REQ-031 SHALL make reset override a same-cycle write (write discarded) and a same-cycle read (no rd_valid).

Configuration
REQ-032 SHALL use macro DMEM_RAM_BANK_DUMP_EN to compile the dump engine in or out.
REQ-033 SHALL, with DMEM_RAM_BANK_DUMP_EN defined, provide the dump engine per REQ-020..REQ-027.
REQ-034 SHALL, with DMEM_RAM_BANK_DUMP_EN undefined, keep the dump ports but tie dump_valid, dump_done and busy to 0 and dump_addr and dump_data to 0, ignore dump_start, and never block req.

Verification
REQ-035 SHALL cover: write 0xDEADBEEF to address 5 with be=1111, read address 5 -> rd=0xDEADBEEF with rd_valid 1 cycle later.
REQ-036 SHALL cover: write 0x11223344 to address 7 with be=1111, then be=0010 with wd=0x0000AA00, read -> rd=0x1122AA44.
REQ-037 SHALL cover: read address DEPTH (129600) -> rd=0, rd_valid=1, oob_err=1; a write there leaves address 0 and DEPTH-1 unchanged.
REQ-038 SHALL cover: same-cycle write 0x5 / read address 3 holding 0x9 -> rd=0x9, and a following read -> 0x5.
REQ-039 SHALL cover: DEPTH=8, dump_start with dump_ready toggling every other cycle -> 8 beats with addresses 0..7 and correct data, dump_done 1 cycle, busy released; a write requested mid-dump is ignored.
REQ-040 SHALL cover: reset asserted at dump_addr=3 -> next cycle busy=0, dump_valid=0, dump_done never asserted, memory contents intact.

Source files
------------

// File: rtl/dmem_ram_bank.sv
// dmem_ram_bank: single-port, byte-writable data memory with an optional linear memory-dump engine.
// Latency: reads return rd/rd_valid one cycle after the request. Dump words appear combinationally for the current dump_addr.
// Backpressure: the dump stream advances only on dump_valid & dump_ready. While busy, access requests are dropped and the requester must stall.
//
// Ports:
//   clk, reset          single clock; synchronous active-high reset
//   req, we, be,        access port: req=1/we=0 is a read, req=1/we=1 is a byte-enabled write
//   address, wd
//   rd, rd_valid        registered read return; rd holds its value between reads
//   oob_err             one-cycle pulse for any access with address >= DEPTH
//   busy                dump in progress (access port blocked)
//   dump_start/ready,   dump stream: words 0..DEPTH-1 then a one-cycle dump_done
//   dump_valid/addr/
//   data/done
//
// Build option: define DMEM_RAM_BANK_DUMP_EN to include the dump engine.
// Without it, the dump ports remain, their outputs are tied to 0, and req is never blocked.
module dmem_ram_bank #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 129600,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   wd,
  output logic [DATA_W-1:0]   rd,
  output logic                rd_valid,
  output logic                oob_err,
  output logic                busy,
  input  logic                dump_start,
  input  logic                dump_ready,
  output logic                dump_valid,
  output logic [ADDR_W-1:0]   dump_addr,
  output logic [DATA_W-1:0]   dump_data,
  output logic                dump_done
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic             in_range;
  logic             acc;
  logic [IDX_W-1:0] idx;

  assign in_range = (address < ADDR_W'(DEPTH));
  assign idx      = address[IDX_W-1:0];
  // Reset and an active dump both suppress the access completely.
  assign acc      = req && !busy && !reset;

  // Memory has no reset so contents survive a reset.
  // A read in the same cycle samples the pre-write word, which gives read-first behaviour.
  always_ff @(posedge clk) begin
    if (acc && we && in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) begin
          mem[idx][b*8 +: 8] <= wd[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd       <= '0;
      rd_valid <= 1'b0;
      oob_err  <= 1'b0;
    end else begin
      rd_valid <= acc && !we;
      oob_err  <= acc && !in_range;
      if (acc && !we) begin
        rd <= in_range ? mem[idx] : '0;
      end
    end
  end

`ifdef DMEM_RAM_BANK_DUMP_EN
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DUMP = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [1:0] state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      dump_addr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (dump_start) begin
            state     <= S_DUMP;
            dump_addr <= '0;
          end
        end
        S_DUMP: begin
          if (dump_ready) begin
            // The last word ends the stream; the address never wraps.
            if (dump_addr == LAST_ADDR) begin
              state <= S_DONE;
            end else begin
              dump_addr <= dump_addr + ADDR_W'(1);
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy       = (state != S_IDLE);
  assign dump_valid = (state == S_DUMP);
  assign dump_done  = (state == S_DONE);
  assign dump_data  = dump_valid ? mem[dump_addr[IDX_W-1:0]] : '0;
`else
  logic unused_dump_in;
  assign unused_dump_in = dump_start ^ dump_ready;

  assign busy       = 1'b0;
  assign dump_valid = 1'b0;
  assign dump_done  = 1'b0;
  assign dump_addr  = '0;
  assign dump_data  = '0;
`endif

endmodule

// File: tb/tb_dmem_ram_bank.sv
module tb_dmem_ram_bank;

  localparam int SD = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-depth instance
  logic        b_reset, b_req, b_we, b_rd_valid, b_oob, b_busy;
  logic        b_dstart, b_dready, b_dvalid, b_ddone;
  logic [3:0]  b_be;
  logic [31:0] b_addr, b_wd, b_rd, b_daddr, b_ddata;

  // DEPTH=8 instance
  logic        s_reset, s_req, s_we, s_rd_valid, s_oob, s_busy;
  logic        s_dstart, s_dready, s_dvalid, s_ddone;
  logic [3:0]  s_be;
  logic [31:0] s_addr, s_wd, s_rd, s_daddr, s_ddata;

  dmem_ram_bank u_big (
    .clk(clk), .reset(b_reset), .req(b_req), .we(b_we), .be(b_be),
    .address(b_addr), .wd(b_wd), .rd(b_rd), .rd_valid(b_rd_valid),
    .oob_err(b_oob), .busy(b_busy), .dump_start(b_dstart),
    .dump_ready(b_dready), .dump_valid(b_dvalid), .dump_addr(b_daddr),
    .dump_data(b_ddata), .dump_done(b_ddone)
  );

  dmem_ram_bank #(.DATA_W(32), .DEPTH(SD), .ADDR_W(32)) u_small (
    .clk(clk), .reset(s_reset), .req(s_req), .we(s_we), .be(s_be),
    .address(s_addr), .wd(s_wd), .rd(s_rd), .rd_valid(s_rd_valid),
    .oob_err(s_oob), .busy(s_busy), .dump_start(s_dstart),
    .dump_ready(s_dready), .dump_valid(s_dvalid), .dump_addr(s_daddr),
    .dump_data(s_ddata), .dump_done(s_ddone)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        vld;
    logic        oob;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic req, input logic we, input logic [3:0] be,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] rd, input logic vld, input logic oob);
    vec_t v;
    v.req = req; v.we = we; v.be = be; v.addr = addr; v.wd = wd;
    v.rd = rd; v.vld = vld; v.oob = oob;
    vq.push_back(v);
  endtask

  // Reference model of the small instance: a plain word array
  logic [31:0] m [SD];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  task automatic s_read(input logic [31:0] a);
    s_req = 1'b1; s_we = 1'b0; s_be = 4'h0; s_addr = a;
    tick();
    s_req = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_rd;
    logic        exp_vld, exp_oob;
    int          beats, done_cnt;
    logic        done_seen, found, rdy;

    b_reset = 1'b1; b_req = 1'b0; b_we = 1'b0; b_be = 4'h0; b_addr = '0; b_wd = '0;
    b_dstart = 1'b0; b_dready = 1'b0;
    s_reset = 1'b1; s_req = 1'b0; s_we = 1'b0; s_be = 4'h0; s_addr = '0; s_wd = '0;
    s_dstart = 1'b0; s_dready = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_rd", b_rd, 0);
    chk("rst_rd_valid", b_rd_valid, 0);
    chk("rst_oob", b_oob, 0);
    chk("rst_busy", b_busy, 0);
    chk("rst_dump_valid", b_dvalid, 0);
    chk("rst_dump_addr", b_daddr, 0);
    chk("rst_dump_done", b_ddone, 0);
    chk("rst_s_busy", s_busy, 0);
    b_reset = 1'b0;
    s_reset = 1'b0;

    // Directed table on the default-depth instance
    //   req we  be     addr        wd            exp rd        vld oob
    add(1, 1, 4'hF, 32'd5,      32'hDEADBEEF, 32'h0,        0, 0);
    add(1, 0, 4'h0, 32'd5,      32'h0,        32'hDEADBEEF, 1, 0);
    add(0, 0, 4'h0, 32'd5,      32'h0,        32'hDEADBEEF, 0, 0);
    add(1, 1, 4'hF, 32'd7,      32'h11223344, 32'hDEADBEEF, 0, 0);
    add(1, 1, 4'h2, 32'd7,      32'h0000AA00, 32'hDEADBEEF, 0, 0);
    add(1, 0, 4'h0, 32'd7,      32'h0,        32'h1122AA44, 1, 0);
    add(1, 1, 4'hF, 32'd0,      32'hA0A0A0A0, 32'h1122AA44, 0, 0);
    add(1, 1, 4'hF, 32'd129599, 32'hB1B1B1B1, 32'h1122AA44, 0, 0);
    add(1, 0, 4'h0, 32'd129600, 32'h0,        32'h0,        1, 1);
    add(1, 1, 4'hF, 32'd129600, 32'hFFFFFFFF, 32'h0,        0, 1);
    add(1, 0, 4'h0, 32'd0,      32'h0,        32'hA0A0A0A0, 1, 0);
    add(1, 0, 4'h0, 32'd129599, 32'h0,        32'hB1B1B1B1, 1, 0);
    add(1, 1, 4'hF, 32'd3,      32'h00000009, 32'hB1B1B1B1, 0, 0);
    add(1, 0, 4'h0, 32'd3,      32'h0,        32'h00000009, 1, 0);
    add(1, 1, 4'hF, 32'd3,      32'h00000005, 32'h00000009, 0, 0);
    add(1, 0, 4'h0, 32'd3,      32'h0,        32'h00000005, 1, 0);
    add(1, 0, 4'h0, 32'hFFFFFFFF, 32'h0,      32'h0,        1, 1);
    add(1, 1, 4'hC, 32'd5,      32'h5A5A0000, 32'h0,        0, 0);
    add(1, 0, 4'h0, 32'd5,      32'h0,        32'h5A5ABEEF, 1, 0);

    for (int i = 0; i < vq.size(); i++) begin
      b_req = vq[i].req; b_we = vq[i].we; b_be = vq[i].be;
      b_addr = vq[i].addr; b_wd = vq[i].wd;
      tick();
      chk($sformatf("vec%0d_rd", i), b_rd, vq[i].rd);
      chk($sformatf("vec%0d_rd_valid", i), b_rd_valid, vq[i].vld);
      chk($sformatf("vec%0d_oob", i), b_oob, vq[i].oob);
      chk($sformatf("vec%0d_busy", i), b_busy, 0);
    end
    b_req = 1'b0;

    // Reset overrides same-cycle write and read; memory survives reset
    b_reset = 1'b1; b_req = 1'b1; b_we = 1'b1; b_be = 4'hF; b_addr = 32'd5; b_wd = 32'h12345678;
    tick();
    chk("rstwr_rd_valid", b_rd_valid, 0);
    chk("rstwr_rd", b_rd, 0);
    b_we = 1'b0;
    tick();
    chk("rstrd_rd_valid", b_rd_valid, 0);
    b_reset = 1'b0;
    tick();
    chk("post_rst_rd", b_rd, 32'h5A5ABEEF);
    chk("post_rst_rd_valid", b_rd_valid, 1);
    b_req = 1'b0;

    // Randomized traffic on the small instance against the word-array model
    for (int i = 0; i < SD; i++) begin
      s_req = 1'b1; s_we = 1'b1; s_be = 4'hF; s_addr = i; s_wd = $urandom;
      m[i] = s_wd;
      tick();
    end
    exp_rd = 32'h0;
    for (int n = 0; n < 300; n++) begin
      s_req  = ($urandom_range(0, 3) != 0);
      s_we   = $urandom_range(0, 1);
      s_be   = 4'($urandom_range(0, 15));
      s_addr = $urandom_range(0, SD + 3);
      s_wd   = $urandom;
      exp_vld = s_req && !s_we;
      exp_oob = s_req && (s_addr >= SD);
      if (exp_vld) exp_rd = (s_addr < SD) ? m[s_addr] : 32'h0;
      if (s_req && s_we && s_addr < SD) m[s_addr] = merge(m[s_addr], s_wd, s_be);
      tick();
      chk($sformatf("rnd%0d_rd", n), s_rd, exp_rd);
      chk($sformatf("rnd%0d_rd_valid", n), s_rd_valid, exp_vld);
      chk($sformatf("rnd%0d_oob", n), s_oob, exp_oob);
    end
    s_req = 1'b0;
    tick();

`ifdef DMEM_RAM_BANK_DUMP_EN
    // Full dump with dump_ready toggling and a write attempted mid-dump
    s_dstart = 1'b1;
    tick();
    s_dstart = 1'b0;
    chk("dump_busy_on", s_busy, 1);
    chk("dump_valid_on", s_dvalid, 1);
    chk("dump_addr_start", s_daddr, 0);
    beats = 0; done_seen = 1'b0; rdy = 1'b0;
    for (int cyc = 0; cyc < 100 && !done_seen; cyc++) begin
      rdy = ~rdy;
      s_dready = rdy;
      s_req = (cyc == 4); s_we = 1'b1; s_be = 4'hF; s_addr = 32'd2; s_wd = 32'hCAFEF00D;
      if (s_dvalid) begin
        chk($sformatf("dump_addr_c%0d", cyc), s_daddr, beats);
        if (s_dready) begin
          if (beats < SD) chk($sformatf("dump_data_b%0d", beats), s_ddata, m[beats]);
          else chk("dump_extra_beat", beats, SD - 1);
          beats++;
        end
      end
      tick();
      if (cyc == 4) begin
        chk("stall_rd_valid", s_rd_valid, 0);
        chk("stall_oob", s_oob, 0);
      end
      if (s_ddone) done_seen = 1'b1;
    end
    s_req = 1'b0;
    s_dready = 1'b0;
    chk("dump_done_seen", done_seen, 1);
    chk("dump_beats", beats, SD);
    chk("dump_done_valid_low", s_dvalid, 0);
    tick();
    chk("dump_done_one_cycle", s_ddone, 0);
    chk("dump_busy_released", s_busy, 0);
    s_read(32'd2);
    chk("dump_write_ignored", s_rd, m[2]);

    // Reset in the middle of a dump
    s_dready = 1'b1; s_dstart = 1'b1;
    tick();
    s_dstart = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (s_dvalid && s_daddr == 32'd3) found = 1'b1;
      else tick();
    end
    chk("abort_reached_addr3", found, 1);
    s_reset = 1'b1;
    tick();
    s_reset = 1'b0;
    chk("abort_busy", s_busy, 0);
    chk("abort_dump_valid", s_dvalid, 0);
    chk("abort_dump_addr", s_daddr, 0);
    chk("abort_dump_done", s_ddone, 0);
    done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (s_ddone) done_cnt++;
    end
    chk("abort_no_done", done_cnt, 0);
    s_dready = 1'b0;
    for (int i = 0; i < SD; i++) begin
      s_read(i);
      chk($sformatf("abort_mem%0d", i), s_rd, m[i]);
    end
`else
    // Dump engine absent: start ignored, outputs tied low, reads never blocked
    s_dready = 1'b1; s_dstart = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_req = 1'b1; s_we = 1'b0; s_addr = i % SD;
      tick();
      s_dstart = 1'b0;
      chk($sformatf("nodump_busy%0d", i), s_busy, 0);
      chk($sformatf("nodump_valid%0d", i), s_dvalid, 0);
      chk($sformatf("nodump_done%0d", i), s_ddone, 0);
      chk($sformatf("nodump_addr%0d", i), s_daddr, 0);
      chk($sformatf("nodump_data%0d", i), s_ddata, 0);
      chk($sformatf("nodump_rd_valid%0d", i), s_rd_valid, 1);
      chk($sformatf("nodump_rd%0d", i), s_rd, m[i % SD]);
    end
    s_req = 1'b0;
    s_dready = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
